// File: rtl/id_ex_wb_pipe.sv
// id_ex_wb_pipe: ID/EX/WB back half of the b-risc integer pipeline with register file.
// Ports:
//   clk          rising-edge clock
//   rf_aresetn   asynchronous active-low reset (register file and both stage registers)
//   id_clr       synchronous clear of the ID register
//   id_stall     hold the ID register (EX loads a bubble meanwhile)
//   ex_clr       synchronous clear of the EX register
//   ex_stall     hold the EX register
//   wb_clr       combinationally suppress the current writeback
//   i_pc         PC of i_instr
//   i_instr      instruction from fetch
//   o_ex_alu_eval EX register ALU result
//   wb_dest_en / wb_dest_reg / wb_dest_data  register file write port
// Macro BRISC_UTYPE_EN: when defined, LUI and AUIPC are executed; otherwise they decode as bubbles.
module id_ex_wb_pipe (
    input  logic        clk,
    input  logic        rf_aresetn,
    input  logic        id_clr,
    input  logic        id_stall,
    input  logic        ex_clr,
    input  logic        ex_stall,
    input  logic        wb_clr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic [31:0] o_ex_alu_eval,
    output logic        wb_dest_en,
    output logic [4:0]  wb_dest_reg,
    output logic [31:0] wb_dest_data
);
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    function automatic alu_op_t dec_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, rs1_val, rs2_val;
    logic [31:0] rf [32];

    assign opcode = i_instr[6:0];
    assign rd     = i_instr[11:7];
    assign f3     = i_instr[14:12];
    assign rs1    = i_instr[19:15];
    assign rs2    = i_instr[24:20];
    assign imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};

    // Write-through bypass: a register written this cycle is read as the value being written.
    assign rs1_val = (rs1 == 5'd0) ? '0 : (wb_dest_en && wb_dest_reg == rs1) ? wb_dest_data : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : (wb_dest_en && wb_dest_reg == rs2) ? wb_dest_data : rf[rs2];

    logic        d_en;
    alu_op_t     d_op;
    logic [31:0] d_a, d_b;

    always_comb begin
        d_en = 1'b0;
        d_op = ALU_ADD;
        d_a  = '0;
        d_b  = '0;
        case (opcode)
            7'b0010011: begin
                d_en = 1'b1;
                // instr[30] only distinguishes SRAI; for ADDI it is an immediate bit.
                d_op = dec_op(f3, i_instr[30] & (f3 == 3'd5));
                d_a  = rs1_val;
                d_b  = imm_i;
            end
            7'b0110011: begin
                d_en = 1'b1;
                d_op = dec_op(f3, i_instr[30]);
                d_a  = rs1_val;
                d_b  = rs2_val;
            end
`ifdef BRISC_UTYPE_EN
            7'b0110111: begin
                d_en = 1'b1;
                d_b  = {i_instr[31:12], 12'b0};
            end
            7'b0010111: begin
                d_en = 1'b1;
                d_a  = i_pc;
                d_b  = {i_instr[31:12], 12'b0};
            end
`endif
            default: ;
        endcase
    end

    logic [31:0] id_pc, id_instr, id_a, id_b;
    alu_op_t     id_op;
    logic        id_en;
    logic [4:0]  id_rd;

    // Unsupported opcodes load an all-zero bubble.
    always_ff @(posedge clk or negedge rf_aresetn) begin
        if (!rf_aresetn || id_clr) begin
            id_pc    <= '0;
            id_instr <= '0;
            id_op    <= ALU_ADD;
            id_a     <= '0;
            id_b     <= '0;
            id_en    <= 1'b0;
            id_rd    <= '0;
        end else if (!id_stall) begin
            id_pc    <= d_en ? i_pc : '0;
            id_instr <= d_en ? i_instr : '0;
            id_op    <= d_op;
            id_a     <= d_a;
            id_b     <= d_b;
            id_en    <= d_en;
            id_rd    <= d_en ? rd : '0;
        end
    end

    logic [31:0] alu;

    always_comb begin
        alu = '0;
        case (id_op)
            ALU_ADD:  alu = id_a + id_b;
            ALU_SUB:  alu = id_a - id_b;
            ALU_SLL:  alu = id_a << id_b[4:0];
            ALU_SLT:  alu = {31'b0, $signed(id_a) < $signed(id_b)};
            ALU_SLTU: alu = {31'b0, id_a < id_b};
            ALU_XOR:  alu = id_a ^ id_b;
            ALU_SRL:  alu = id_a >> id_b[4:0];
            ALU_SRA:  alu = $unsigned($signed(id_a) >>> id_b[4:0]);
            ALU_OR:   alu = id_a | id_b;
            ALU_AND:  alu = id_a & id_b;
            default:  alu = '0;
        endcase
    end

    logic [31:0] ex_pc, ex_instr, ex_res;
    logic        ex_en;
    logic [4:0]  ex_rd;

    // A stalled ID feeding a running EX must not hand over the same instruction twice.
    always_ff @(posedge clk or negedge rf_aresetn) begin
        if (!rf_aresetn || ex_clr || (!ex_stall && id_stall)) begin
            ex_pc    <= '0;
            ex_instr <= '0;
            ex_res   <= '0;
            ex_en    <= 1'b0;
            ex_rd    <= '0;
        end else if (!ex_stall) begin
            ex_pc    <= id_pc;
            ex_instr <= id_instr;
            ex_res   <= alu;
            ex_en    <= id_en;
            ex_rd    <= id_rd;
        end
    end

    // pc/instr travel with the instruction for observability but feed no logic here.
    logic unused_trace;
    assign unused_trace = ^{ex_pc, ex_instr};

    assign o_ex_alu_eval = ex_res;
    assign wb_dest_en    = ex_en & ~wb_clr & (ex_rd != 5'd0);
    assign wb_dest_reg   = ex_rd;
    assign wb_dest_data  = ex_res;

    always_ff @(posedge clk or negedge rf_aresetn) begin
        if (!rf_aresetn) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_dest_en) begin
            rf[wb_dest_reg] <= wb_dest_data;
        end
    end
endmodule

// File: tb/tb_id_ex_wb_pipe.sv
// tb_id_ex_wb_pipe: directed table-driven bench for id_ex_wb_pipe plus stall/clear/reset sequences.
module tb_id_ex_wb_pipe;
    logic        clk = 1'b0;
    logic        rf_aresetn, id_clr, id_stall, ex_clr, ex_stall, wb_clr;
    logic [31:0] i_pc, i_instr, o_ex_alu_eval, wb_dest_data;
    logic        wb_dest_en;
    logic [4:0]  wb_dest_reg;
    int          tests = 0;
    int          fails = 0;

    id_ex_wb_pipe dut (
        .clk(clk), .rf_aresetn(rf_aresetn), .id_clr(id_clr), .id_stall(id_stall),
        .ex_clr(ex_clr), .ex_stall(ex_stall), .wb_clr(wb_clr), .i_pc(i_pc), .i_instr(i_instr),
        .o_ex_alu_eval(o_ex_alu_eval), .wb_dest_en(wb_dest_en), .wb_dest_reg(wb_dest_reg),
        .wb_dest_data(wb_dest_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic        en;
        logic [4:0]  rg;
        logic [31:0] d;
    } vec_t;

    localparam int N = 31;
    vec_t tv [N];

    function automatic logic [31:0] ii(input logic [11:0] imm, input logic [4:0] s1,
                                       input logic [2:0] fn, input logic [4:0] rdx);
        return {imm, s1, fn, rdx, 7'h13};
    endfunction

    function automatic logic [31:0] rr(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1,
                                       input logic [2:0] fn, input logic [4:0] rdx);
        return {f7, s2, s1, fn, rdx, 7'h33};
    endfunction

    task automatic tick(input logic [31:0] ins);
        i_instr = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic en, input logic [4:0] rg, input logic [31:0] d);
        tests++;
        if (wb_dest_en !== en || wb_dest_reg !== rg || wb_dest_data !== d || o_ex_alu_eval !== d) begin
            fails++;
            $display("FAIL %s: got en=%0b reg=%0d data=%h alu=%h, want en=%0b reg=%0d data=%h",
                     nm, wb_dest_en, wb_dest_reg, wb_dest_data, o_ex_alu_eval, en, rg, d);
        end
    endtask

    initial begin
        tv[0]  = '{32'hFFF00093, 1'b1, 5'd1, 32'hFFFFFFFF};
        tv[1]  = '{32'h00000013, 1'b0, 5'd0, 32'h0};
        tv[2]  = '{ii(12'd2, 5'd1, 3'd0, 5'd2), 1'b1, 5'd2, 32'h1};
        tv[3]  = '{ii(12'd5, 5'd0, 3'd0, 5'd1), 1'b1, 5'd1, 32'h5};
        tv[4]  = '{ii(12'd7, 5'd0, 3'd0, 5'd2), 1'b1, 5'd2, 32'h7};
        tv[5]  = '{ii(12'd1, 5'd0, 3'd0, 5'd6), 1'b1, 5'd6, 32'h1};
        tv[6]  = '{rr(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 1'b1, 5'd3, 32'hFFFFFFFE};
        tv[7]  = '{rr(7'h00, 5'd2, 5'd1, 3'd3, 5'd4), 1'b1, 5'd4, 32'h1};
        tv[8]  = '{rr(7'h00, 5'd1, 5'd3, 3'd2, 5'd9), 1'b1, 5'd9, 32'h1};
        tv[9]  = '{rr(7'h20, 5'd6, 5'd3, 3'd5, 5'd5), 1'b1, 5'd5, 32'hFFFFFFFF};
        tv[10] = '{rr(7'h00, 5'd6, 5'd3, 3'd5, 5'd10), 1'b1, 5'd10, 32'h7FFFFFFF};
        tv[11] = '{rr(7'h00, 5'd3, 5'd1, 3'd3, 5'd11), 1'b1, 5'd11, 32'h1};
        tv[12] = '{rr(7'h00, 5'd2, 5'd1, 3'd4, 5'd12), 1'b1, 5'd12, 32'h2};
        tv[13] = '{rr(7'h00, 5'd2, 5'd1, 3'd6, 5'd13), 1'b1, 5'd13, 32'h7};
        tv[14] = '{rr(7'h00, 5'd2, 5'd1, 3'd7, 5'd14), 1'b1, 5'd14, 32'h5};
        tv[15] = '{rr(7'h00, 5'd6, 5'd1, 3'd1, 5'd15), 1'b1, 5'd15, 32'hA};
        tv[16] = '{ii(12'd5, 5'd0, 3'd0, 5'd0), 1'b0, 5'd0, 32'h5};
        tv[17] = '{rr(7'h00, 5'd0, 5'd0, 3'd0, 5'd7), 1'b1, 5'd7, 32'h0};
        tv[18] = '{ii(12'hFFF, 5'd1, 3'd4, 5'd16), 1'b1, 5'd16, 32'hFFFFFFFA};
        tv[19] = '{ii(12'hFFF, 5'd3, 3'd2, 5'd17), 1'b1, 5'd17, 32'h1};
        tv[20] = '{ii(12'hFFF, 5'd1, 3'd3, 5'd18), 1'b1, 5'd18, 32'h1};
        tv[21] = '{ii(12'h010, 5'd1, 3'd6, 5'd19), 1'b1, 5'd19, 32'h15};
        tv[22] = '{ii(12'h0F0, 5'd3, 3'd7, 5'd20), 1'b1, 5'd20, 32'hF0};
        tv[23] = '{ii(12'h004, 5'd1, 3'd1, 5'd21), 1'b1, 5'd21, 32'h50};
        tv[24] = '{ii(12'h01C, 5'd3, 3'd5, 5'd22), 1'b1, 5'd22, 32'hF};
        tv[25] = '{ii(12'h41C, 5'd3, 3'd5, 5'd23), 1'b1, 5'd23, 32'hFFFFFFFF};
        tv[26] = '{rr(7'h00, 5'd3, 5'd3, 3'd0, 5'd25), 1'b1, 5'd25, 32'hFFFFFFFC};
        tv[27] = '{ii(12'hC00, 5'd1, 3'd0, 5'd24), 1'b1, 5'd24, 32'hFFFFFC05};
`ifdef BRISC_UTYPE_EN
        tv[28] = '{32'h12345437, 1'b1, 5'd8, 32'h12345000};
        tv[29] = '{32'h00001D17, 1'b1, 5'd26, 32'h00001100};
`else
        tv[28] = '{32'h12345437, 1'b0, 5'd0, 32'h0};
        tv[29] = '{32'h00001D17, 1'b0, 5'd0, 32'h0};
`endif
        tv[30] = '{32'h0000A083, 1'b0, 5'd0, 32'h0};

        rf_aresetn = 1'b0;
        id_clr = 1'b1;
        ex_clr = 1'b1;
        wb_clr = 1'b1;
        id_stall = 1'b0;
        ex_stall = 1'b0;
        i_pc = 32'h100;
        i_instr = 32'hFFF00093;
        repeat (4) @(posedge clk);
        #1;
        chk("reset", 1'b0, 5'd0, 32'h0);
        rf_aresetn = 1'b1;
        id_clr = 1'b0;
        ex_clr = 1'b0;
        wb_clr = 1'b0;

        for (int k = 0; k <= N; k++) begin
            tick(k < N ? tv[k].ins : 32'h0);
            if (k > 0) chk($sformatf("vec%0d", k - 1), tv[k - 1].en, tv[k - 1].rg, tv[k - 1].d);
        end

        tick(ii(12'd1, 5'd0, 3'd0, 5'd27));
        #2 rf_aresetn = 1'b0;
        #1 chk("rst_mid", 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1 rf_aresetn = 1'b1;
        tick(rr(7'h00, 5'd0, 5'd1, 3'd0, 5'd26));
        chk("rst_discard", 1'b0, 5'd0, 32'h0);
        tick(32'h0);
        chk("rst_rf_clear", 1'b1, 5'd26, 32'h0);

        tick(ii(12'd11, 5'd0, 3'd0, 5'd1));
        tick(ii(12'd22, 5'd0, 3'd0, 5'd2));
        chk("stall_pre", 1'b1, 5'd1, 32'd11);
        id_stall = 1'b1;
        tick(ii(12'd33, 5'd0, 3'd0, 5'd3));
        chk("stall_b1", 1'b0, 5'd0, 32'h0);
        tick(ii(12'd33, 5'd0, 3'd0, 5'd3));
        chk("stall_b2", 1'b0, 5'd0, 32'h0);
        id_stall = 1'b0;
        tick(ii(12'd33, 5'd0, 3'd0, 5'd3));
        chk("stall_rel", 1'b1, 5'd2, 32'd22);
        tick(32'h0);
        chk("stall_next", 1'b1, 5'd3, 32'd33);
        tick(32'h0);
        chk("stall_tail", 1'b0, 5'd0, 32'h0);

        tick(ii(12'd44, 5'd0, 3'd0, 5'd4));
        ex_clr = 1'b1;
        tick(ii(12'd55, 5'd0, 3'd0, 5'd5));
        chk("exclr_bubble", 1'b0, 5'd0, 32'h0);
        ex_clr = 1'b0;
        tick(32'h0);
        chk("exclr_next", 1'b1, 5'd5, 32'd55);
        tick(rr(7'h00, 5'd0, 5'd4, 3'd0, 5'd6));
        tick(32'h0);
        chk("exclr_nowrite", 1'b1, 5'd6, 32'h0);

        id_clr = 1'b1;
        tick(ii(12'd99, 5'd0, 3'd0, 5'd9));
        id_clr = 1'b0;
        tick(32'h0);
        chk("idclr", 1'b0, 5'd0, 32'h0);

        tick(ii(12'd77, 5'd0, 3'd0, 5'd7));
        tick(32'h0);
        chk("wbclr_pre", 1'b1, 5'd7, 32'd77);
        wb_clr = 1'b1;
        #1 chk("wbclr_on", 1'b0, 5'd7, 32'd77);
        tick(32'h0);
        wb_clr = 1'b0;
        tick(rr(7'h00, 5'd0, 5'd7, 3'd0, 5'd8));
        tick(32'h0);
        chk("wbclr_nowrite", 1'b1, 5'd8, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
